// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte push into a circular FIFO,
// serialised LSB-first at CLKS_PER_BIT clocks per bit with back-to-back frames.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          tx_oeb,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 17;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_n;
  logic [AW:0]   r_wptr, r_rptr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_tx, w_tx_n;
  logic          r_oeb;
  logic [AW:0]   w_level;
  logic          w_full, w_empty, w_push, w_pop;

  // Pointers carry a wrap bit, so occupancy is a plain difference.
  assign w_level  = r_wptr - r_rptr;
  assign w_full   = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty  = (w_level == '0);
  assign w_push   = wr_valid & wr_ready;

  assign wr_ready = ~r_oeb & ~w_full;
  assign tx       = r_tx;
  assign tx_oeb   = r_oeb;
  assign busy     = (r_state != IDLE) | ~w_empty;
  assign level    = w_level;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        if (tx_en && !w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rptr[AW-1:0]];
          w_state_n = START;
        end
      end
      START: if (r_cnt == BIT_LAST) begin
        w_cnt_n   = '0;
        w_bit_n   = '0;
        w_state_n = DATA;
      end
      DATA: if (r_cnt == BIT_LAST) begin
        w_cnt_n   = '0;
        w_shift_n = {1'b0, r_shift[7:1]};
        w_bit_n   = r_bit + 3'd1;
        if (r_bit == 3'd7) w_state_n = STOP;
      end
      STOP: if (r_cnt == STOP_LAST) begin
        w_cnt_n = '0;
        // Pop on the last stop cycle so the next start bit follows with no gap.
        if (tx_en && !w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rptr[AW-1:0]];
          w_state_n = START;
        end else begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_oeb   <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_oeb   <= 1'b0;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end
endmodule
